// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one fixed-latency memory between a CPU port and a DMA port
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   output logic              err0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic              err1,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              owner,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t state_q, state_d;
   logic last_q, last_d, owner_q, owner_d, we_q, we_d, err_q, err_d, gnt;
   logic [3:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d, gnt_addr;
   logic [DATA_W-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   // grant selection, transaction sequencing and read-data capture
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      owner_d  = owner_q;
      we_d     = we_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      gnt      = (req0 && req1) ? ~last_q : req1;
      gnt_addr = gnt ? addr1 : addr0;
      case (state_q)
         IDLE: if (req0 || req1) begin
            owner_d = gnt;
            last_d  = gnt;
            we_d    = gnt ? we1 : we0;
            err_d   = |gnt_addr[1:0];
            cnt_d   = '0;
            if (|gnt_addr[1:0]) state_d = RESP;
            else begin
               addr_d  = gnt_addr;
               wdata_d = gnt ? wdata1 : wdata0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(MEM_LAT - 1)) begin
               state_d = RESP;
               if (!we_q && owner_q) rdata1_d = mem_rdata;
               if (!we_q && !owner_q) rdata0_d = mem_rdata;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // state and latched transaction registers; reset abandons any transaction in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         owner_q  <= 1'b0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end
   assign ack0      = (state_q == RESP) && !owner_q;
   assign ack1      = (state_q == RESP) && owner_q;
   assign err0      = ack0 && err_q;
   assign err1      = ack1 && err_q;
   assign mem_en    = (state_q == ACCESS) && (cnt_q == 4'd0);
   assign mem_we    = mem_en && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign owner     = owner_q;
   assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiter instances (MEM_LAT 1 and 3) checked cycle by cycle against a transaction-level model
module tb_mem_port_arbiter;
   localparam int RAND = 0, DIRECT = 1, HOLD = 2;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [1:0] req0, we0, req1, we1;
   logic [31:0] addr0 [2], wdata0 [2], addr1 [2], wdata1 [2], mem_rdata [2];
   wire [1:0] ack0, err0, ack1, err1, mem_en, mem_we, owner, busy;
   wire [31:0] rdata0 [2], rdata1 [2], mem_addr [2], mem_wdata [2];
   always #5 clk = ~clk;
   for (genvar g = 0; g < 2; g++) begin : gi
      mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g == 0 ? 1 : 3)) u_dut (
         .clk(clk), .rst(rst),
         .req0(req0[g]), .we0(we0[g]), .addr0(addr0[g]), .wdata0(wdata0[g]),
         .ack0(ack0[g]), .err0(err0[g]), .rdata0(rdata0[g]),
         .req1(req1[g]), .we1(we1[g]), .addr1(addr1[g]), .wdata1(wdata1[g]),
         .ack1(ack1[g]), .err1(err1[g]), .rdata1(rdata1[g]),
         .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
         .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
         .owner(owner[g]), .busy(busy[g]));
   end
   int ncmp = 0, nfail = 0, cyc = 0, mode = DIRECT;
   bit dead = 1'b0, found;
   logic r_req [2][2], r_we [2][2];
   logic [31:0] r_addr [2][2], r_wdata [2][2];
   logic m_busy [2], m_own [2], m_last [2], m_mis [2], m_we [2];
   int m_s [2], m_e [2];
   logic [31:0] m_maddr [2], m_mwd [2], m_rd [2][2];
   logic [31:0] rlog [2][4096];
   int en_cnt [2], nack [2], rep [2], first_ack [2], prev_ack [2], err_cnt [2];
   function automatic int lat(int k);
      return k == 0 ? 1 : 3;
   endfunction
   task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s[lat=%0d] cyc=%0d observed=%h expected=%h", tag, lat(k), cyc, obs, exp);
      end
   endtask
   task automatic apply();
      for (int k = 0; k < 2; k++) begin
         req0[k] = r_req[k][0]; we0[k] = r_we[k][0]; addr0[k] = r_addr[k][0]; wdata0[k] = r_wdata[k][0];
         req1[k] = r_req[k][1]; we1[k] = r_we[k][1]; addr1[k] = r_addr[k][1]; wdata1[k] = r_wdata[k][1];
      end
   endtask
   task automatic set_port(int p, logic rq, logic w, logic [31:0] a, logic [31:0] d);
      for (int k = 0; k < 2; k++) begin
         r_req[k][p] = rq; r_we[k][p] = w; r_addr[k][p] = a; r_wdata[k][p] = d;
      end
   endtask
   task automatic rand_port(int k, int p);
      r_req[k][p] = $urandom_range(2) != 0;
      r_we[k][p] = 1'($urandom_range(1));
      r_addr[k][p] = $urandom;
      if ($urandom_range(7) != 0) r_addr[k][p][1:0] = 2'b00;
      r_wdata[k][p] = $urandom;
   endtask
   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = 0; m_own[k] = 0; m_last[k] = 1; m_mis[k] = 0; m_we[k] = 0;
         m_s[k] = 0; m_e[k] = 0; m_maddr[k] = 0; m_mwd[k] = 0; m_rd[k][0] = 0; m_rd[k][1] = 0;
      end
   endtask
   task automatic clr();
      for (int k = 0; k < 2; k++) begin
         en_cnt[k] = 0; nack[k] = 0; rep[k] = 0; first_ack[k] = -1; prev_ack[k] = -1; err_cnt[k] = 0;
      end
   endtask
   task automatic check_all(int k);
      logic a, e;
      logic [7:0] ec, oc;
      a = m_busy[k] && cyc == m_e[k];
      e = m_busy[k] && !m_mis[k] && cyc == m_s[k] + 1;
      ec = {m_busy[k], e, e && m_we[k], a && !m_own[k], a && m_own[k],
            a && m_mis[k] && !m_own[k], a && m_mis[k] && m_own[k], m_own[k]};
      oc = {busy[k], mem_en[k], mem_we[k], ack0[k], ack1[k], err0[k], err1[k], owner[k]};
      chk("ctl{busy,en,we,ack0,ack1,err0,err1,owner}", k, 32'(oc), 32'(ec));
      chk("mem_addr", k, mem_addr[k], m_maddr[k]);
      chk("mem_wdata", k, mem_wdata[k], m_mwd[k]);
      chk("rdata0", k, rdata0[k], m_rd[k][0]);
      chk("rdata1", k, rdata1[k], m_rd[k][1]);
   endtask
   task automatic step();
      logic was [2];
      logic g;
      int cur;
      for (int k = 0; k < 2; k++) begin
         if (m_busy[k] && cyc == m_e[k] && !m_mis[k] && !m_we[k])
            m_rd[k][m_own[k]] = rlog[k][(m_s[k] + lat(k)) % 4096];
         check_all(k);
         en_cnt[k] += int'(mem_en[k]);
         if (ack0[k] || ack1[k]) begin
            cur = int'(ack1[k]);
            if (nack[k] > 0 && cur == prev_ack[k]) rep[k]++;
            if (nack[k] == 0) first_ack[k] = cur;
            prev_ack[k] = cur;
            nack[k]++;
            err_cnt[k] += int'(err0[k] || err1[k]);
         end
         was[k] = m_busy[k];
         if (m_busy[k] && cyc == m_e[k]) m_busy[k] = 0;
         for (int p = 0; p < 2; p++) begin
            if (mode == RAND) begin
               if ((was[k] && int'(m_own[k]) == p) || $urandom_range(3) == 0) rand_port(k, p);
            end else if (mode == DIRECT && was[k] && !m_busy[k] && int'(m_own[k]) == p) r_req[k][p] = 0;
         end
         mem_rdata[k] = dead ? 32'hDEADBEEF : $urandom;
         rlog[k][cyc % 4096] = mem_rdata[k];
         if (!was[k] && (r_req[k][0] || r_req[k][1])) begin
            g = (r_req[k][0] && r_req[k][1]) ? !m_last[k] : r_req[k][1];
            m_own[k] = g; m_last[k] = g; m_s[k] = cyc;
            m_mis[k] = r_addr[k][g][1:0] != 2'b00;
            m_we[k] = r_we[k][g];
            if (!m_mis[k]) begin
               m_maddr[k] = r_addr[k][g];
               m_mwd[k] = r_wdata[k][g];
            end
            m_e[k] = cyc + (m_mis[k] ? 1 : lat(k) + 1);
            m_busy[k] = 1;
         end
      end
      apply();
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask
   task automatic drain();
      mode = DIRECT;
      set_port(0, 0, 0, 0, 0);
      set_port(1, 0, 0, 0, 0);
      repeat (6) step();
   endtask
   initial begin
      model_reset();
      clr();
      set_port(0, 0, 0, 0, 0);
      set_port(1, 0, 0, 0, 0);
      apply();
      mem_rdata[0] = 0;
      mem_rdata[1] = 0;
      #1 rst = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) check_all(k);
      @(negedge clk);
      rst = 1'b0;
      // CPU aligned read returning a fixed memory word
      dead = 1'b1;
      set_port(0, 1, 0, 32'h10, 0);
      repeat (8) step();
      dead = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk("p1_rdata0", k, rdata0[k], 32'hDEADBEEF);
         chk("p1_mem_en_count", k, en_cnt[k], 1);
         chk("p1_ack_count", k, nack[k], 1);
         chk("p1_acked_port", k, first_ack[k], 0);
      end
      // DMA write leaves rdata1 untouched
      drain();
      clr();
      set_port(1, 1, 1, 32'h20, 32'h12345678);
      repeat (8) step();
      for (int k = 0; k < 2; k++) begin
         chk("p2_rdata1_kept", k, rdata1[k], 0);
         chk("p2_mem_en_count", k, en_cnt[k], 1);
         chk("p2_acked_port", k, first_ack[k], 1);
      end
      // both ports requesting continuously: grants alternate starting with CPU
      drain();
      clr();
      mode = HOLD;
      set_port(0, 1, 0, 32'h100, 0);
      set_port(1, 1, 0, 32'h200, 0);
      repeat (24) step();
      for (int k = 0; k < 2; k++) begin
         chk("p3_repeat_acks", k, rep[k], 0);
         chk("p3_first_port", k, first_ack[k], 0);
         chk("p3_enough_acks", k, 32'(nack[k] >= 4), 1);
      end
      // misaligned CPU read: immediate error ack, no memory strobe
      drain();
      clr();
      set_port(0, 1, 0, 32'h13, 0);
      repeat (6) step();
      for (int k = 0; k < 2; k++) begin
         chk("p4_mem_en_count", k, en_cnt[k], 0);
         chk("p4_err_count", k, err_cnt[k], 1);
         chk("p4_ack_count", k, nack[k], 1);
      end
      // randomized traffic
      mode = RAND;
      repeat (600) step();
      // asynchronous reset while the MEM_LAT=3 instance is in ACCESS
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (m_busy[1] && !m_mis[1] && cyc > m_s[1] && cyc <= m_s[1] + 3) found = 1'b1;
         else step();
      end
      chk("rst_access_found", 1, 32'(found), 1);
      #2 rst = 1'b1;
      #1;
      model_reset();
      for (int k = 0; k < 2; k++) check_all(k);
      mode = HOLD;
      set_port(0, 1, 0, 32'h40, 0);
      set_port(1, 1, 0, 32'h80, 0);
      apply();
      @(negedge clk);
      cyc++;
      rst = 1'b0;
      clr();
      repeat (12) step();
      for (int k = 0; k < 2; k++) begin
         chk("p6_first_port", k, first_ack[k], 0);
         chk("p6_repeat_acks", k, rep[k], 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
